freq_monitor_ctrl: RTL and testbench

Measurement sequencer and range checker placed directly downstream of the frequency counter, in the reference clock domain. It issues `Start` pulses with a latched window length, captures each `result` on `Finish`, and averages 2^AVG_LOG2 results. It compares the average against programmable limits and drives a hysteresis-filtered `Fault_o` flag, plus a timeout when a measurement never completes (for example, a dead test clock).

---
 rtl/freq_mon_pkg.sv | 25 ++
 rtl/freq_mon_hyst.sv | 57 +++++
 rtl/freq_monitor_ctrl.sv | 171 +++++++++++++++++
 tb/tb_freq_monitor_ctrl.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_mon_pkg.sv
// Purpose: shared state encoding and width helpers for the frequency monitor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package freq_mon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_ACCUM,
        S_GAP
    } state_e;

    // The accumulator holds 2^avg_log2 full-scale results without overflow.
    function automatic int sum_width(input int width, input int avg_log2);
        return width + avg_log2;
    endfunction

    // The wait counter must reach (window << 2) + margin.
    function automatic int to_cnt_width(input int width);
        return width + 3;
    endfunction

endpackage

// File: rtl/freq_mon_hyst.sv
// Purpose: bad/good run counters filtering range events into a sticky fault flag.
// Latency: Fault_o updates at the same edge that samples ev_vld.
// Backpressure: none; accepts one event per cycle.
//
// Ports:
//   Clk_ref_i  reference clock
//   Rst_i      synchronous active-high reset
//   ev_vld     one event this cycle
//   ev_bad     event is out of range (1) or in range (0)
//   Fault_o    filtered fault flag
module freq_mon_hyst #(
    parameter int FAULT_CNT = 3
) (
    input  logic Clk_ref_i,
    input  logic Rst_i,
    input  logic ev_vld,
    input  logic ev_bad,
    output logic Fault_o
);

    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_CNT);

    logic [RUN_W-1:0] bad_run;
    logic [RUN_W-1:0] good_run;
    logic [RUN_W-1:0] bad_nxt;
    logic [RUN_W-1:0] good_nxt;

    // Runs saturate so a long streak never wraps back below the threshold.
    always_comb begin
        bad_nxt  = (bad_run == RUN_MAX) ? bad_run : bad_run + 1'b1;
        good_nxt = (good_run == RUN_MAX) ? good_run : good_run + 1'b1;
    end

    always_ff @(posedge Clk_ref_i) begin
        if (Rst_i) begin
            bad_run  <= '0;
            good_run <= '0;
            Fault_o  <= 1'b0;
        end else if (ev_vld) begin
            if (ev_bad) begin
                good_run <= '0;
                bad_run  <= bad_nxt;
                if (bad_nxt == RUN_MAX) begin
                    Fault_o <= 1'b1;
                end
            end else begin
                bad_run  <= '0;
                good_run <= good_nxt;
                if (good_nxt == RUN_MAX) begin
                    Fault_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/freq_monitor_ctrl.sv
// Purpose: sequences counter measurements, averages results, range-checks the average.
// Latency: Start_o 3 cycles after Enable_i; Avg_valid_o/Fault_o 1 cycle after Finish_i.
// Backpressure: none; Finish_i is only accepted while waiting for a measurement.
//
// Ports:
//   Clk_ref_i, Rst_i          reference clock, synchronous active-high reset
//   Enable_i, C_cfg_i         run control and requested window length
//   Thr_lo_i, Thr_hi_i        inclusive in-range limits for the average
//   Start_o, C_o              start pulse and latched window to the counter
//   Result_i, Finish_i        counter result and completion pulse
//   Avg_o, Avg_valid_o        last average and its update pulse
//   Fault_o, Timeout_o        filtered range fault, measurement timeout pulse
//   Busy_o                    high while not idle
module freq_monitor_ctrl
    import freq_mon_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int AVG_LOG2  = 2,
    parameter int FAULT_CNT = 3,
    parameter int TO_MARGIN = 32,
    parameter int GAP_CYC   = 4
) (
    input  logic             Clk_ref_i,
    input  logic             Rst_i,
    input  logic             Enable_i,
    input  logic [WIDTH-1:0] C_cfg_i,
    input  logic [WIDTH-1:0] Thr_lo_i,
    input  logic [WIDTH-1:0] Thr_hi_i,
    output logic             Start_o,
    output logic [WIDTH-1:0] C_o,
    input  logic [WIDTH-1:0] Result_i,
    input  logic             Finish_i,
    output logic [WIDTH-1:0] Avg_o,
    output logic             Avg_valid_o,
    output logic             Fault_o,
    output logic             Timeout_o,
    output logic             Busy_o
);

    localparam int SUM_W = sum_width(WIDTH, AVG_LOG2);
    localparam int TO_W  = to_cnt_width(WIDTH);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int GAP_W = $clog2(GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** AVG_LOG2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_e           state;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TO_W-1:0]  wait_q;
    logic [GAP_W-1:0] gap_q;

    logic [TO_W-1:0]  wait_nxt;
    logic [TO_W-1:0]  to_limit;
    logic [WIDTH-1:0] avg_now;
    logic             to_hit;
    logic             avg_full;
    logic             avg_bad;
    logic             ev_vld;
    logic             ev_bad;

    // The match is taken on the incremented value so Timeout_o lands exactly
    // (C_o << 2) + TO_MARGIN cycles after the Start_o cycle.
    assign wait_nxt = wait_q + 1'b1;
    assign to_limit = (TO_W'(C_o) << 2) + TO_W'(TO_MARGIN);
    assign to_hit   = (state == S_WAIT) && !Finish_i && (wait_nxt == to_limit);

    assign avg_full = (state == S_ACCUM) && (cnt_q == CNT_FULL);
    assign avg_now  = WIDTH'(sum_q >> AVG_LOG2);
    // Inverted limits make both comparisons able to fire, so every average is bad.
    assign avg_bad  = (avg_now < Thr_lo_i) || (avg_now > Thr_hi_i);

    // Events are decoded combinationally so the hysteresis register updates
    // on the same edge as Avg_valid_o / Timeout_o.
    assign ev_vld = to_hit || avg_full;
    assign ev_bad = to_hit || avg_bad;

    always_ff @(posedge Clk_ref_i) begin
        if (Rst_i) begin
            state       <= S_IDLE;
            sum_q       <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            gap_q       <= '0;
            C_o         <= '0;
            Avg_o       <= '0;
            Start_o     <= 1'b0;
            Avg_valid_o <= 1'b0;
            Timeout_o   <= 1'b0;
            Busy_o      <= 1'b0;
        end else begin
            Start_o     <= 1'b0;
            Avg_valid_o <= 1'b0;
            Timeout_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    sum_q <= '0;
                    cnt_q <= '0;
                    if (Enable_i && (C_cfg_i != '0)) begin
                        state  <= S_LOAD;
                        Busy_o <= 1'b1;
                    end
                end
                S_LOAD: begin
                    C_o   <= C_cfg_i;
                    state <= S_START;
                end
                S_START: begin
                    Start_o <= 1'b1;
                    wait_q  <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    wait_q <= wait_nxt;
                    // Finish_i takes priority over a coincident timeout match.
                    if (Finish_i) begin
                        sum_q <= sum_q + SUM_W'(Result_i);
                        cnt_q <= cnt_q + 1'b1;
                        state <= S_ACCUM;
                    end else if (wait_nxt == to_limit) begin
                        Timeout_o <= 1'b1;
                        sum_q     <= '0;
                        cnt_q     <= '0;
                        gap_q     <= '0;
                        state     <= S_GAP;
                    end
                end
                S_ACCUM: begin
                    if (avg_full) begin
                        Avg_o       <= avg_now;
                        Avg_valid_o <= 1'b1;
                        sum_q       <= '0;
                        cnt_q       <= '0;
                    end
                    gap_q <= '0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (Enable_i) begin
                            state <= S_LOAD;
                        end else begin
                            // A partial average is discarded on the way to idle.
                            state  <= S_IDLE;
                            Busy_o <= 1'b0;
                            sum_q  <= '0;
                            cnt_q  <= '0;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    Busy_o <= 1'b0;
                end
            endcase
        end
    end

    freq_mon_hyst #(
        .FAULT_CNT(FAULT_CNT)
    ) u_hyst (
        .Clk_ref_i(Clk_ref_i),
        .Rst_i    (Rst_i),
        .ev_vld   (ev_vld),
        .ev_bad   (ev_bad),
        .Fault_o  (Fault_o)
    );

endmodule

// File: tb/tb_freq_monitor_ctrl.sv
// Purpose: self-checking bench for freq_monitor_ctrl acting as the frequency counter.
// Latency: n/a.
// Backpressure: n/a.
module tb_freq_monitor_ctrl;

    localparam int WIDTH     = 16;
    localparam int AVG_LOG2  = 2;
    localparam int FAULT_CNT = 3;
    localparam int TO_MARGIN = 32;
    localparam int GAP_CYC   = 4;

    typedef logic [WIDTH-1:0] res_arr_t [4];
    typedef int dly_arr_t [4];
    typedef bit flag_arr_t [4];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] c_cfg = '0;
    logic [WIDTH-1:0] thr_lo = '0;
    logic [WIDTH-1:0] thr_hi = '0;
    logic [WIDTH-1:0] result = '0;
    logic             finish = 1'b0;
    logic             start;
    logic [WIDTH-1:0] c_out;
    logic [WIDTH-1:0] avg;
    logic             avg_valid;
    logic             fault;
    logic             timeout;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_start = 0;
    int n_to = 0;
    int n_avgv = 0;

    // Hysteresis reference state.
    int m_bad = 0;
    int m_good = 0;
    bit m_fault = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start) n_start <= n_start + 1;
        if (timeout) n_to <= n_to + 1;
        if (avg_valid) n_avgv <= n_avgv + 1;
    end

    freq_monitor_ctrl #(
        .WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .FAULT_CNT(FAULT_CNT),
        .TO_MARGIN(TO_MARGIN), .GAP_CYC(GAP_CYC)
    ) dut (
        .Clk_ref_i  (clk),
        .Rst_i      (rst),
        .Enable_i   (enable),
        .C_cfg_i    (c_cfg),
        .Thr_lo_i   (thr_lo),
        .Thr_hi_i   (thr_hi),
        .Start_o    (start),
        .C_o        (c_out),
        .Result_i   (result),
        .Finish_i   (finish),
        .Avg_o      (avg),
        .Avg_valid_o(avg_valid),
        .Fault_o    (fault),
        .Timeout_o  (timeout),
        .Busy_o     (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_bad = 0;
        m_good = 0;
        m_fault = 1'b0;
    endtask

    task automatic model_event(input bit bad);
        if (bad) begin
            m_good = 0;
            if (m_bad < FAULT_CNT) m_bad++;
            if (m_bad == FAULT_CNT) m_fault = 1'b1;
        end else begin
            m_bad = 0;
            if (m_good < FAULT_CNT) m_good++;
            if (m_good == FAULT_CNT) m_fault = 1'b0;
        end
    endtask

    function automatic int ref_avg(input res_arr_t r);
        return (int'(r[0]) + int'(r[1]) + int'(r[2]) + int'(r[3])) / 4;
    endfunction

    function automatic bit ref_bad(input int a, input int lo, input int hi);
        return (a < lo) || (a > hi);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        finish = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_for_start(input int budget, output bit seen, output int sc);
        seen = 1'b0;
        sc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (start) begin
                seen = 1'b1;
                sc = cyc;
                return;
            end
        end
    endtask

    // Plays the counter for one measurement; optionally injects a Finish_i
    // during the following gap, which must be ignored.
    task automatic one_meas(input logic [WIDTH-1:0] r, input int d, input bit stray,
                            output bit seen, output int sc, output bit vld_after);
        vld_after = 1'b0;
        wait_for_start(400, seen, sc);
        if (!seen) return;
        repeat (d) @(negedge clk);
        result = r;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        result = WIDTH'($urandom);
        @(negedge clk);
        vld_after = avg_valid;
        if (stray) begin
            result = '1;
            finish = 1'b1;
            @(negedge clk);
            finish = 1'b0;
        end
    endtask

    task automatic run_avg(input res_arr_t r, input dly_arr_t d, input flag_arr_t stray,
                           output bit starts_ok, output bit valid_ok, output bit spacing_ok,
                           output logic [WIDTH-1:0] a, output logic f);
        bit seen;
        bit vld;
        int sc;
        int prev_sc = 0;
        starts_ok = 1'b1;
        valid_ok = 1'b1;
        spacing_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            one_meas(r[i], d[i], stray[i], seen, sc, vld);
            if (!seen) begin
                starts_ok = 1'b0;
                break;
            end
            if (vld != (i == 3)) valid_ok = 1'b0;
            // Start-to-start = measurement time (Start cycle through Finish
            // cycle, i.e. d+1) + gap + 3.
            if (i > 0 && (sc - prev_sc) != d[i-1] + 1 + GAP_CYC + 3) spacing_ok = 1'b0;
            prev_sc = sc;
        end
        a = avg;
        f = fault;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL go_idle: busy=%0b required 0", busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({start, avg_valid, fault, timeout, busy, c_out, avg} !== '0) begin
            n_errors++;
            $display("FAIL reset_hold: outputs=%h required 0",
                     {start, avg_valid, fault, timeout, busy, c_out, avg});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({start, busy, c_out} !== '0) begin
            n_errors++;
            $display("FAIL reset_idle: start/busy/c=%h required 0", {start, busy, c_out});
        end
        model_reset();
    endtask

    task automatic test_start_path();
        c_cfg = 16'd20;
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, start, c_out} !== {1'b1, 1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL start_edge0: busy=%0b start=%0b c=%0d required 1 0 0", busy, start, c_out);
        end
        @(negedge clk);
        n_checks++;
        if ({start, c_out} !== {1'b0, 16'd20}) begin
            n_errors++;
            $display("FAIL start_edge1: start=%0b c=%0d required 0 20", start, c_out);
        end
        @(negedge clk);
        n_checks++;
        if ({start, c_out} !== {1'b1, 16'd20}) begin
            n_errors++;
            $display("FAIL start_edge2: start=%0b c=%0d required 1 20", start, c_out);
        end
        @(negedge clk);
        n_checks++;
        if (start !== 1'b0) begin
            n_errors++;
            $display("FAIL start_width: start=%0b required 0", start);
        end
        do_reset();
    endtask

    task automatic test_averaging();
        bit s_ok, v_ok, sp_ok;
        logic [WIDTH-1:0] a;
        logic f;
        thr_lo = 16'd90;
        thr_hi = 16'd110;
        c_cfg = 16'd20;
        enable = 1'b1;
        run_avg('{16'd100, 16'd102, 16'd98, 16'd100}, '{2, 5, 0, 9}, '{0, 0, 0, 0},
                s_ok, v_ok, sp_ok, a, f);
        model_event(1'b0);
        n_checks++;
        if (!(s_ok && v_ok && sp_ok)) begin
            n_errors++;
            $display("FAIL avg_flow: starts=%0b valid=%0b spacing=%0b required 1 1 1", s_ok, v_ok, sp_ok);
        end
        n_checks++;
        if (a !== 16'd100) begin
            n_errors++;
            $display("FAIL avg_value: avg=%0d required 100", a);
        end
        n_checks++;
        if (f !== 1'b0) begin
            n_errors++;
            $display("FAIL avg_fault: fault=%0b required 0", f);
        end
        go_idle();
    endtask

    task automatic test_fault_set_clear();
        bit s_ok, v_ok, sp_ok;
        logic [WIDTH-1:0] a;
        logic f;
        logic [WIDTH-1:0] lvl;
        bit exp_f;
        thr_lo = 16'd90;
        thr_hi = 16'd110;
        c_cfg = 16'd20;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lvl = (i < 3) ? 16'd120 : 16'd100;
            exp_f = (i == 2) || (i == 3) || (i == 4);
            run_avg('{lvl, lvl, lvl, lvl}, '{1, 3, 2, 4}, '{0, 0, 0, 0}, s_ok, v_ok, sp_ok, a, f);
            model_event(i < 3);
            n_checks++;
            if (!(s_ok && v_ok) || a !== lvl || f !== exp_f) begin
                n_errors++;
                $display("FAIL fault_hyst[%0d]: avg=%0d fault=%0b ok=%0b%0b required avg=%0d fault=%0b",
                         i, a, f, s_ok, v_ok, lvl, exp_f);
            end
        end
        go_idle();
    endtask

    task automatic test_random_avg();
        bit s_ok, v_ok, sp_ok;
        logic [WIDTH-1:0] a;
        logic f;
        res_arr_t r;
        dly_arr_t d;
        int e_avg;
        c_cfg = 16'd20;
        enable = 1'b1;
        for (int it = 0; it < 8; it++) begin
            thr_lo = WIDTH'($urandom_range(0, 300));
            thr_hi = WIDTH'($urandom_range(0, 300));
            for (int k = 0; k < 4; k++) begin
                r[k] = WIDTH'($urandom_range(0, 400));
                d[k] = $urandom_range(0, 20);
            end
            run_avg(r, d, '{0, 0, 0, 0}, s_ok, v_ok, sp_ok, a, f);
            e_avg = ref_avg(r);
            model_event(ref_bad(e_avg, int'(thr_lo), int'(thr_hi)));
            n_checks++;
            if (!(s_ok && v_ok && sp_ok) || int'(a) != e_avg || f !== m_fault) begin
                n_errors++;
                $display("FAIL rand_avg[%0d]: avg=%0d fault=%0b ok=%0b%0b%0b required avg=%0d fault=%0b (lo=%0d hi=%0d)",
                         it, a, f, s_ok, v_ok, sp_ok, e_avg, m_fault, thr_lo, thr_hi);
            end
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        bit seen, s_ok, v_ok, sp_ok;
        int sc;
        int st0, av0;
        logic [WIDTH-1:0] a;
        logic f;
        thr_lo = 16'd90;
        thr_hi = 16'd110;
        c_cfg = 16'd20;
        enable = 1'b1;
        wait_for_start(50, seen, sc);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        result = 16'd500;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        repeat (2) @(negedge clk);
        st0 = n_start;
        av0 = n_avgv;
        repeat (30) @(negedge clk);
        n_checks++;
        if (!seen || busy !== 1'b0 || n_start != st0 || n_avgv != av0) begin
            n_errors++;
            $display("FAIL enable_drop: seen=%0b busy=%0b new_starts=%0d new_avgs=%0d required 1 0 0 0",
                     seen, busy, n_start - st0, n_avgv - av0);
        end
        enable = 1'b1;
        run_avg('{16'd100, 16'd100, 16'd100, 16'd100}, '{0, 1, 2, 3}, '{0, 0, 0, 0},
                s_ok, v_ok, sp_ok, a, f);
        model_event(1'b0);
        n_checks++;
        if (!(s_ok && v_ok) || a !== 16'd100) begin
            n_errors++;
            $display("FAIL partial_discard: avg=%0d ok=%0b%0b required 100 11", a, s_ok, v_ok);
        end
        go_idle();
    endtask

    task automatic test_zero_window();
        int st0;
        c_cfg = '0;
        enable = 1'b1;
        st0 = n_start;
        repeat (100) @(negedge clk);
        n_checks++;
        if (n_start != st0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_window: starts=%0d busy=%0b required 0 0", n_start - st0, busy);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_coincident();
        bit s_ok, v_ok, sp_ok;
        logic [WIDTH-1:0] a;
        logic f;
        res_arr_t r;
        int to0;
        int e_avg;
        thr_lo = '0;
        thr_hi = '1;
        c_cfg = 16'd10;
        for (int k = 0; k < 4; k++) r[k] = WIDTH'($urandom_range(0, 1000));
        to0 = n_to;
        enable = 1'b1;
        // Delay 71 puts Finish_i on the very edge where the 72-cycle timeout matches.
        run_avg(r, '{3, 71, 5, 2}, '{1, 0, 1, 0}, s_ok, v_ok, sp_ok, a, f);
        go_idle();
        e_avg = ref_avg(r);
        model_event(1'b0);
        n_checks++;
        if (!(s_ok && v_ok && sp_ok) || int'(a) != e_avg) begin
            n_errors++;
            $display("FAIL stray_coinc_avg: avg=%0d ok=%0b%0b%0b required avg=%0d ok=111",
                     a, s_ok, v_ok, sp_ok, e_avg);
        end
        n_checks++;
        if (n_to != to0) begin
            n_errors++;
            $display("FAIL coinc_timeout: timeouts=%0d required 0", n_to - to0);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int sc;
        int n;
        do_reset();
        c_cfg = 16'd10;
        thr_lo = 16'd90;
        thr_hi = 16'd110;
        enable = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_for_start(400, seen, sc);
            n = 0;
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (timeout) begin
                    n = i;
                    break;
                end
            end
            model_event(1'b1);
            if (t == 2) enable = 1'b0;
            n_checks++;
            if (!seen || n != 72 || fault !== m_fault) begin
                n_errors++;
                $display("FAIL timeout[%0d]: seen=%0b delay=%0d fault=%0b required 1 72 %0b",
                         t, seen, n, fault, m_fault);
            end
            @(negedge clk);
            n_checks++;
            if (timeout !== 1'b0) begin
                n_errors++;
                $display("FAIL timeout_width[%0d]: timeout=%0b required 0", t, timeout);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        bit seen, vld, s_ok, v_ok, sp_ok;
        int sc;
        logic [WIDTH-1:0] a;
        logic f;
        c_cfg = 16'd20;
        thr_lo = 16'd90;
        thr_hi = 16'd110;
        enable = 1'b1;
        one_meas(16'd1000, 2, 1'b0, seen, sc, vld);
        one_meas(16'd1000, 2, 1'b0, seen, sc, vld);
        wait_for_start(400, seen, sc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({start, avg_valid, fault, timeout, busy, c_out, avg} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: outputs=%h required 0",
                     {start, avg_valid, fault, timeout, busy, c_out, avg});
        end
        rst = 1'b0;
        model_reset();
        run_avg('{16'd200, 16'd200, 16'd200, 16'd200}, '{1, 2, 3, 4}, '{0, 0, 0, 0},
                s_ok, v_ok, sp_ok, a, f);
        model_event(1'b1);
        n_checks++;
        if (!(s_ok && v_ok) || a !== 16'd200 || f !== m_fault) begin
            n_errors++;
            $display("FAIL reset_fresh: avg=%0d fault=%0b ok=%0b%0b required 200 %0b 11",
                     a, f, s_ok, v_ok, m_fault);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_start_path();
        test_averaging();
        test_fault_set_clear();
        test_random_avg();
        test_enable_drop();
        test_zero_window();
        test_stray_coincident();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
